// File: rtl/trans_seq_pkg.sv
// Shared types for the transaction sequence generator: the FSM state
// encoding, the protocol length and the state-to-phase decode.
package trans_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRANS,
        ST_START,
        ST_A,
        ST_B,
        ST_C,
        ST_END,
        ST_GAP
    } trans_state_t;

    // Number of protocol phases: trans, start_trans, a, b, c, end_trans.
    localparam int TRANS_SEQ_LEN = 6;

    // Phase vector ordering, MSB first: {trans, start_trans, a, b, c, end_trans}.
    typedef logic [TRANS_SEQ_LEN-1:0] phase_vec_t;

    // One-hot phase pattern driven while the FSM sits in a given state.
    function automatic phase_vec_t phase_of(input trans_state_t s);
        phase_vec_t p;
        p = '0;
        case (s)
            ST_TRANS: p = 6'b100000;
            ST_START: p = 6'b010000;
            ST_A:     p = 6'b001000;
            ST_B:     p = 6'b000100;
            ST_C:     p = 6'b000010;
            ST_END:   p = 6'b000001;
            default:  p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/trans_seq_gap_timer.sv
// Loadable down-counter that times the idle gap after end_trans.
// 'load' presets the count to GAP_CYCLES; 'expired' marks the last gap cycle.
module trans_seq_gap_timer #(
    parameter int GAP_CYCLES = 0
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(GAP_CYCLES);

    logic [CW-1:0] count;

    // Preset on load, then count down to zero and hold there.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // Count reads 1 in the final gap cycle, so the FSM leaves on the next edge.
    assign expired = (count == CW'(1));

endmodule

// File: rtl/trans_seq_gen.sv
// Registered six-phase transaction generator:
//   trans -> start_trans -> a -> b -> c -> end_trans, one phase per cycle,
// with req/busy control, abort, programmable post-transaction gap and a
// wrapping completion counter.
// Optional macro TRANS_SEQ_GEN_SVA_EN adds protocol assertions; behaviour
// is identical with or without it.
module trans_seq_gen
    import trans_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             abort,
    output logic             trans,
    output logic             start_trans,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             end_trans,
    output logic             busy,
    output logic             aborted,
    output logic [CNT_W-1:0] txn_count
);

    trans_state_t state;
    trans_state_t state_nxt;
    phase_vec_t   phases;
    logic         abort_hit;
    logic         gap_load;
    logic         gap_expired;

    // Gap length is timed outside the FSM; it is preset while in END.
    assign gap_load = (state == ST_END);

    trans_seq_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .expired (gap_expired)
    );

    // Next-state decode; abort only bites in the five phases before END.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nxt = state;
        abort_hit = 1'b0;
        case (state)
            ST_IDLE:  if (req) state_nxt = ST_TRANS;
            ST_TRANS: state_nxt = abort ? ST_IDLE : ST_START;
            ST_START: state_nxt = abort ? ST_IDLE : ST_A;
            ST_A:     state_nxt = abort ? ST_IDLE : ST_B;
            ST_B:     state_nxt = abort ? ST_IDLE : ST_C;
            ST_C:     state_nxt = abort ? ST_IDLE : ST_END;
            ST_END: begin
                if (GAP_CYCLES > 0) state_nxt = ST_GAP;
                else if (req)       state_nxt = ST_TRANS;
                else                state_nxt = ST_IDLE;
            end
            ST_GAP:   if (gap_expired) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort && (state inside {ST_TRANS, ST_START, ST_A, ST_B, ST_C})) begin
            abort_hit = 1'b1;
        end
    end

    // State register plus outputs registered from the next state, so every
    // output changes on the same edge as the state with no input-to-output path.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phases    <= '0;
            busy      <= 1'b0;
            aborted   <= 1'b0;
            txn_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from
            // the pre-edge values, independent of statement order.
            state   <= state_nxt;
            phases  <= phase_of(state_nxt);
            busy    <= (state_nxt != ST_IDLE);
            aborted <= abort_hit;
            if (state == ST_END) begin
                txn_count <= txn_count + CNT_W'(1);
            end
        end
    end

    assign {trans, start_trans, a, b, c, end_trans} = phases;

`ifdef TRANS_SEQ_GEN_SVA_EN
    sequence s_trans_seq;
        trans ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans;
    endsequence

    // A transaction that is not cancelled runs all six phases in order.
    property p_trans_seq;
        @(posedge sysclk) disable iff (!rst_n || abort || aborted)
            $rose(trans) |-> s_trans_seq;
    endproperty

    a_trans_seq: assert property (p_trans_seq);

    a_phase_onehot0: assert property (
        @(posedge sysclk) disable iff (!rst_n)
            $onehot0({trans, start_trans, a, b, c, end_trans})
    );
`endif

endmodule

// File: tb/tb_trans_seq_gen.sv
// Scoreboard bench for trans_seq_gen. Two instances: dut_a (GAP_CYCLES=0,
// CNT_W=8) and dut_b (GAP_CYCLES=3, CNT_W=2). Stimulus pushes the expected
// per-cycle observation {phases, busy, aborted, count} tagged with the cycle
// number; a monitor on the falling edge pops and compares.
module tb_trans_seq_gen;

    logic sysclk = 1'b0;
    logic rst_n;
    logic req_a, abort_a, req_b, abort_b;

    logic       trans_a, start_a, a_a, b_a, c_a, end_a, busy_a, aborted_a;
    logic [7:0] cnt_a;
    logic       trans_b, start_b, a_b, b_b, c_b, end_b, busy_b, aborted_b;
    logic [1:0] cnt_b;

    trans_seq_gen #(.GAP_CYCLES(0), .CNT_W(8)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .req(req_a), .abort(abort_a),
        .trans(trans_a), .start_trans(start_a), .a(a_a), .b(b_a), .c(c_a),
        .end_trans(end_a), .busy(busy_a), .aborted(aborted_a), .txn_count(cnt_a)
    );

    trans_seq_gen #(.GAP_CYCLES(3), .CNT_W(2)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .req(req_b), .abort(abort_b),
        .trans(trans_b), .start_trans(start_b), .a(a_b), .b(b_b), .c(c_b),
        .end_trans(end_b), .busy(busy_b), .aborted(aborted_b), .txn_count(cnt_b)
    );

    always #5 sysclk = ~sysclk;

    // cyc = number of rising edges seen so far.
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] obs;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] obs_a, obs_b;
    assign obs_a = {trans_a, start_a, a_a, b_a, c_a, end_a, busy_a, aborted_a, cnt_a};
    assign obs_b = {trans_b, start_b, a_b, b_b, c_b, end_b, busy_b, aborted_b, 6'd0, cnt_b};

    task automatic check(input string nm, input int at, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc %0d: got ph=%b busy=%b ab=%b cnt=%0d, required ph=%b busy=%b ab=%b cnt=%0d",
                      nm, at, act[15:10], act[9], act[8], act[7:0],
                      exp[15:10], exp[9], exp[8], exp[7:0]);
    endtask

    function automatic logic [15:0] mk(input logic [5:0] ph, input logic bsy,
                                       input logic ab, input int cnt);
        return {ph, bsy, ab, 8'(cnt)};
    endfunction

    task automatic push(input bit to_b, input int c, input logic [15:0] o);
        exp_t x;
        x.cyc = c;
        x.obs = o;
        if (to_b) qb.push_back(x);
        else      qa.push_back(x);
    endtask

    task automatic push_idle(input bit to_b, input int c, input int cnt);
        push(to_b, c, mk(6'b000000, 1'b0, 1'b0, cnt));
    endtask

    // Six one-hot phases starting at cycle st, busy high, count unchanged.
    task automatic push_txn(input bit to_b, input int st, input int cnt);
        logic [5:0] ph;
        ph = 6'b100000;
        for (int i = 0; i < 6; i++) push(to_b, st + i, mk(ph >> i, 1'b1, 1'b0, cnt));
    endtask

    // Advance to cycle n, landing 2 ns after its rising edge.
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge sysclk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            check((e.cyc == cyc) ? "dut_a" : "dut_a_late", e.cyc, obs_a, e.obs);
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            check((e.cyc == cyc) ? "dut_b" : "dut_b_late", e.cyc, obs_b, e.obs);
        end
    end

    initial begin
        rst_n = 1'b0; req_a = 1'b0; abort_a = 1'b0; req_b = 1'b0; abort_b = 1'b0;

        // Reset state on both instances.
        push_idle(0, 2, 0);
        push_idle(1, 2, 0);
        step_to(3);
        rst_n = 1'b1;
        push_idle(0, 4, 0);
        push_idle(0, 5, 0);

        // Single req pulse: phases in cycles 6..11, count 1 afterwards.
        step_to(5);
        req_a = 1'b1;
        push_txn(0, 6, 0);
        push_idle(0, 12, 1);
        step_to(6);
        req_a = 1'b0;

        // req held: two back-to-back transactions with no idle between.
        push_idle(0, 13, 1);
        push_idle(0, 14, 1);
        step_to(14);
        req_a = 1'b1;
        push_txn(0, 15, 1);
        push_txn(0, 21, 2);
        push_idle(0, 27, 3);
        push_idle(0, 28, 3);
        push_idle(0, 29, 3);
        step_to(25);
        req_a = 1'b0;

        // Abort during b: zeros next cycle, aborted pulse, count held.
        step_to(29);
        req_a = 1'b1;
        push(0, 30, mk(6'b100000, 1'b1, 1'b0, 3));
        push(0, 31, mk(6'b010000, 1'b1, 1'b0, 3));
        push(0, 32, mk(6'b001000, 1'b1, 1'b0, 3));
        push(0, 33, mk(6'b000100, 1'b1, 1'b0, 3));
        push(0, 34, mk(6'b000000, 1'b0, 1'b1, 3));
        push_idle(0, 35, 3);
        push_idle(0, 36, 3);
        push_idle(0, 37, 3);
        step_to(30);
        req_a = 1'b0;
        step_to(33);
        abort_a = 1'b1;
        step_to(34);
        abort_a = 1'b0;

        // Abort during end_trans is ignored and the count still increments.
        step_to(37);
        req_a = 1'b1;
        push_txn(0, 38, 3);
        push_idle(0, 44, 4);
        push_idle(0, 45, 4);
        push_idle(0, 46, 4);
        step_to(38);
        req_a = 1'b0;
        step_to(43);
        abort_a = 1'b1;
        step_to(44);
        abort_a = 1'b0;

        // req and abort together in IDLE: request wins.
        step_to(46);
        req_a = 1'b1;
        abort_a = 1'b1;
        push_txn(0, 47, 4);
        push_idle(0, 53, 5);
        push_idle(0, 54, 5);
        push_idle(0, 55, 5);
        step_to(47);
        req_a = 1'b0;
        abort_a = 1'b0;

        // Asynchronous reset during phase a, then a clean sequence.
        step_to(55);
        req_a = 1'b1;
        push(0, 56, mk(6'b100000, 1'b1, 1'b0, 5));
        push(0, 57, mk(6'b010000, 1'b1, 1'b0, 5));
        push_idle(0, 58, 0);
        push_idle(0, 59, 0);
        push_idle(0, 60, 0);
        push_idle(0, 61, 0);
        push_txn(0, 62, 0);
        push_idle(0, 68, 1);
        push_idle(0, 69, 1);
        push_idle(1, 58, 0);
        step_to(56);
        req_a = 1'b0;
        step_to(58);
        rst_n = 1'b0;
        step_to(60);
        rst_n = 1'b1;
        step_to(61);
        req_a = 1'b1;
        step_to(62);
        req_a = 1'b0;

        // dut_b: req held, 3 gap cycles + 1 idle between transactions,
        // 2-bit count runs 1, 2, 3, 0, 1.
        step_to(70);
        req_b = 1'b1;
        push_idle(1, 70, 0);
        for (int k = 0; k < 5; k++) begin
            push_txn(1, 71 + 10 * k, k % 4);
            for (int g = 0; g < 3; g++) push(1, 77 + 10 * k + g, mk(6'b000000, 1'b1, 1'b0, (k + 1) % 4));
            push_idle(1, 80 + 10 * k, (k + 1) % 4);
        end
        push_idle(1, 121, 1);
        step_to(115);
        req_b = 1'b0;

        step_to(124);
        check("qa_drained", cyc, 16'(qa.size()), 16'd0);
        check("qb_drained", cyc, 16'(qb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
